cp0_exc_ctrl: RTL and testbench

Exception/interrupt controller that owns the CP0 Status (96), Cause (104) and EPC (112) registers and sequences pipeline redirection on syscall, eret and hardware interrupts. It sits beside the ID stage. It arbitrates simultaneous events, updates the CP0 registers atomically, and holds a flush/redirect request until the fetch stage acknowledges it. MTC0/MFC0 access uses the same {cs,sel} 8-bit address space as the CP0 register file.

---
 rtl/cp0_exc_ctrl.sv | 131 +++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: owns Status, Cause and EPC, arbitrates
// syscall/eret/interrupt events and holds a fetch redirect until acknowledged.
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_0080,
  parameter int          NUM_INT    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [29:0] id_pc,
  input  logic        exc_syscall,
  input  logic        exc_eret,
  input  logic [5:0]  int_req,
  input  logic        mtc0_we,
  input  logic [7:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [7:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out,
  output logic        fsm_state
);

  localparam logic [7:0] ADDR_STATUS = 8'd96;
  localparam logic [7:0] ADDR_CAUSE  = 8'd104;
  localparam logic [7:0] ADDR_EPC    = 8'd112;
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      state;
  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [29:0] epc;
  logic [5:0]  int_pend;
  logic        take_sys;
  logic        take_eret;
  logic        take_int;

  assign int_pend  = int_req & im[5:0] & {NUM_INT{ie & ~exl}};
  assign take_sys  = (state == IDLE) && id_valid && exc_syscall;
  assign take_eret = (state == IDLE) && id_valid && !exc_syscall && exc_eret;
  assign take_int  = (state == IDLE) && id_valid && !exc_syscall && !exc_eret && (|int_pend);

  // Redirect handshake: redirect_valid/redirect_pc stay stable from the event
  // edge until the edge on which redirect_ack is sampled high; the transfer
  // completes on that edge and valid drops right after. Ack outside REDIRECT
  // has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      im             <= '0;
      exl            <= 1'b0;
      ie             <= 1'b0;
      ip             <= '0;
      exc_code       <= '0;
      epc            <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      ip <= int_req;

      // Software writes first, so an event later in this block overrides them.
      if (mtc0_we) begin
        case (mtc0_addr)
          ADDR_STATUS: begin
            im  <= mtc0_data[15:8];
            exl <= mtc0_data[1];
            ie  <= mtc0_data[0];
          end
          ADDR_EPC: epc <= mtc0_data[31:2];
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (take_sys || take_int) begin
            epc            <= id_pc;
            exc_code       <= take_sys ? EXC_SYSCALL : EXC_INT;
            exl            <= 1'b1;
            redirect_pc    <= HANDLER_PC;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            state          <= REDIRECT;
          end else if (take_eret) begin
            exl            <= 1'b0;
            redirect_pc    <= {epc, 2'b00};
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            state          <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redirect_ack) begin
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign status_out = {16'b0, im, 6'b0, exl, ie};
  assign cause_out  = {16'b0, ip, 3'b0, exc_code, 2'b00};
  assign epc_out    = {epc, 2'b00};
  assign fsm_state  = (state == REDIRECT);

  always_comb begin
    mfc0_data = 32'b0;
    case (mfc0_addr)
      ADDR_STATUS: mfc0_data = status_out;
      ADDR_CAUSE:  mfc0_data = cause_out;
      ADDR_EPC:    mfc0_data = epc_out;
      default:     mfc0_data = 32'b0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus random traffic, all checked
// against a word-level model of the CP0 registers and the redirect handshake.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [29:0] id_pc;
  logic        exc_syscall;
  logic        exc_eret;
  logic [5:0]  int_req;
  logic        mtc0_we;
  logic [7:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [7:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic [31:0] epc_out;
  logic        fsm_state;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_status;
  logic [31:0] m_cause;
  logic [31:0] m_epc;
  logic        m_busy;
  logic [31:0] m_rpc;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .exc_syscall(exc_syscall), .exc_eret(exc_eret), .int_req(int_req),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .status_out(status_out),
    .cause_out(cause_out), .epc_out(epc_out), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (a == 8'd96)  return m_status;
    if (a == 8'd104) return m_cause;
    if (a == 8'd112) return m_epc;
    return 32'h0;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [5:0]  pend;
    logic [31:0] n_status, n_cause, n_epc;
    if (rst) begin
      m_status = 0; m_cause = 0; m_epc = 0; m_busy = 0; m_rpc = 0;
      return;
    end
    pend     = int_req & m_status[13:8] & {6{m_status[0] & ~m_status[1]}};
    n_status = m_status;
    n_epc    = m_epc;
    n_cause  = (m_cause & 32'h0000_007C) | (32'(int_req) << 10);
    if (mtc0_we && mtc0_addr == 8'd96)  n_status = mtc0_data & 32'h0000_FF03;
    if (mtc0_we && mtc0_addr == 8'd112) n_epc    = mtc0_data & 32'hFFFF_FFFC;
    if (!m_busy) begin
      if (id_valid && (exc_syscall || (!exc_eret && pend != 0))) begin
        n_epc    = {id_pc, 2'b00};
        n_cause  = (n_cause & ~32'h7C) | (exc_syscall ? 32'd8 << 2 : 32'd0);
        n_status = n_status | 32'h2;
        m_rpc    = 32'h80;
        m_busy   = 1;
      end else if (id_valid && exc_eret) begin
        n_status = n_status & ~32'h2;
        m_rpc    = m_epc;
        m_busy   = 1;
      end
    end else if (redirect_ack) begin
      m_busy = 0;
    end
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
  endtask

  task automatic compare_all();
    check("flush", 32'(flush), 32'(m_busy));
    check("redirect_valid", 32'(redirect_valid), 32'(m_busy));
    if (m_busy) check("redirect_pc", redirect_pc, m_rpc);
    check("status", status_out, m_status);
    check("cause", cause_out, m_cause);
    check("epc", epc_out, m_epc);
    check("mfc0_data", mfc0_data, model_read(mfc0_addr));
  endtask

  // driver: one clock with the currently set inputs, then check
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    rst = 0; id_valid = 0; id_pc = '0; exc_syscall = 0; exc_eret = 0;
    mtc0_we = 0; mtc0_addr = 0; mtc0_data = 0; redirect_ack = 0;
  endtask

  task automatic write_cp0(input logic [7:0] a, input logic [31:0] d);
    quiet(); mtc0_we = 1; mtc0_addr = a; mtc0_data = d;
    step();
    mtc0_we = 0;
  endtask

  int rv_cycles;

  initial begin
    quiet(); int_req = 0; mfc0_addr = 8'd96;
    m_status = 0; m_cause = 0; m_epc = 0; m_busy = 0; m_rpc = 0;

    // reset, then syscall
    rst = 1; step(); step(); rst = 0;
    check("rst_status", status_out, 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    id_valid = 1; exc_syscall = 1; id_pc = 30'h100; mfc0_addr = 8'd112;
    step();
    check("sys_epc", epc_out, 32'h400);
    check("sys_exccode", 32'(cause_out[6:2]), 32'd8);
    check("sys_exl", 32'(status_out[1]), 32'd1);
    check("sys_rpc", redirect_pc, 32'h80);
    check("sys_mfc0_epc", mfc0_data, 32'h400);
    quiet(); step();
    check("sys_flush_hold", 32'(flush), 32'd1);
    redirect_ack = 1; step();
    check("sys_flush_drop", 32'(flush), 32'd0);

    // eret with ack low for 3 cycles
    quiet(); id_valid = 1; exc_eret = 1; rv_cycles = 0;
    step();
    if (redirect_valid) rv_cycles++;
    quiet();
    for (int i = 0; i < 3; i++) begin
      step();
      if (redirect_valid) rv_cycles++;
    end
    check("eret_rpc", redirect_pc, 32'h400);
    redirect_ack = 1; step();
    check("eret_rv_cycles", 32'(rv_cycles), 32'd4);
    check("eret_exl", 32'(status_out[1]), 32'd0);

    // interrupt enabled
    write_cp0(8'd96, 32'h0000_0101);
    quiet(); int_req = 6'b000001; id_valid = 1; id_pc = 30'h55;
    step();
    check("int_rpc", redirect_pc, 32'h80);
    check("int_exccode", 32'(cause_out[6:2]), 32'd0);
    check("int_exl", 32'(status_out[1]), 32'd1);
    quiet(); redirect_ack = 1; step();
    // interrupt masked by IE=0
    write_cp0(8'd96, 32'h0000_0100);
    quiet(); id_valid = 1; id_pc = 30'h66;
    step(); step();
    check("mask_no_redirect", 32'(redirect_valid), 32'd0);
    check("mask_ip", 32'(cause_out[15:10]), 32'b000001);

    // syscall and interrupt together
    write_cp0(8'd96, 32'h0000_0101);
    quiet(); id_valid = 1; exc_syscall = 1; id_pc = 30'h77;
    step();
    check("simul_exccode", 32'(cause_out[6:2]), 32'd8);
    quiet(); redirect_ack = 1; step();
    quiet(); id_valid = 1; id_pc = 30'h78;
    step(); step();
    check("simul_no_int_exl", 32'(redirect_valid), 32'd0);

    // MTC0 EPC collides with syscall
    quiet(); mtc0_we = 1; mtc0_addr = 8'd112; mtc0_data = 32'h1234;
    id_valid = 1; exc_syscall = 1; id_pc = 30'h40;
    step();
    check("collide_epc", epc_out, 32'h100);

    // reset mid-redirect
    quiet(); rst = 1; step();
    check("rst_mid_flush", 32'(flush), 32'd0);
    check("rst_mid_rv", 32'(redirect_valid), 32'd0);
    check("rst_mid_regs", status_out | cause_out | epc_out, 32'd0);
    quiet(); int_req = 0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      id_valid    = $urandom_range(0, 1);
      id_pc       = 30'($urandom);
      exc_syscall = ($urandom_range(0, 7) == 0);
      exc_eret    = ($urandom_range(0, 6) == 0);
      int_req     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      mtc0_we     = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: mtc0_addr = 8'd96;
        1: mtc0_addr = 8'd104;
        2: mtc0_addr = 8'd112;
        default: mtc0_addr = 8'($urandom);
      endcase
      mtc0_data    = $urandom;
      case ($urandom_range(0, 3))
        0: mfc0_addr = 8'd96;
        1: mfc0_addr = 8'd104;
        2: mfc0_addr = 8'd112;
        default: mfc0_addr = 8'($urandom);
      endcase
      redirect_ack = $urandom_range(0, 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
